// File: rtl/wb_regfile_pkg.sv
// Shared constants and select encodings for the writeback register file slice.
package wb_regfile_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      SEL_ALU = 1'b0,
      SEL_MEM = 1'b1
   } memtoreg_sel_e;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback inputs, decode read ports and forwarding/status outputs.
interface wb_regfile_if #(
   parameter int unsigned DATA_W = 32
);
   import wb_regfile_pkg::*;

   logic                  RegWrite;
   logic                  MemtoReg;
   logic [DATA_W-1:0]     ReadData_in;
   logic [DATA_W-1:0]     ALU_in;
   logic [REG_ADDR_W-1:0] rd_in;
   logic [REG_ADDR_W-1:0] rs_addr;
   logic [REG_ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0]     rs_data;
   logic [DATA_W-1:0]     rt_data;
   logic [DATA_W-1:0]     wb_data;
   logic                  wb_valid;
   logic [15:0]           wr_count;

   modport slave (
      input  RegWrite, MemtoReg, ReadData_in, ALU_in, rd_in, rs_addr, rt_addr,
      output rs_data, rt_data, wb_data, wb_valid, wr_count
   );

   modport master (
      output RegWrite, MemtoReg, ReadData_in, ALU_in, rd_in, rs_addr, rt_addr,
      input  rs_data, rt_data, wb_data, wb_valid, wr_count
   );

endinterface

// File: rtl/wb_regfile_regfile_bank.sv
// Register array with one synchronous write port and two combinational read ports.
module regfile_bank
   import wb_regfile_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BANK_REGS = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [REG_ADDR_W-1:0] raddr_a,
   input  logic [REG_ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0]     rdata_a,
   output logic [DATA_W-1:0]     rdata_b
);

   logic [DATA_W-1:0] regs [BANK_REGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < BANK_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && waddr != REG_ZERO) begin
         regs[waddr] <= wdata;
      end
   end

   // Register 0 is hardwired to zero on both ports.
   always_comb begin
      rdata_a = (raddr_a == REG_ZERO) ? '0 : regs[raddr_a];
      rdata_b = (raddr_b == REG_ZERO) ? '0 : regs[raddr_b];
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: result mux, commit counter, optional
// same-cycle write-to-read bypass enabled by defining WB_BYPASS_EN.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        reset,
   wb_regfile_if.slave bus
);

   logic [DATA_W-1:0] wb_data;
   logic              wb_valid;
   logic [DATA_W-1:0] bank_rs;
   logic [DATA_W-1:0] bank_rt;
   logic [15:0]       wr_cnt_q;

   always_comb begin
      wb_data  = (memtoreg_sel_e'(bus.MemtoReg) == SEL_MEM) ? bus.ReadData_in : bus.ALU_in;
      wb_valid = bus.RegWrite && (bus.rd_in != REG_ZERO);
   end

   regfile_bank #(
      .DATA_W    (DATA_W),
      .BANK_REGS (NUM_REGS)
   ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .we      (wb_valid),
      .waddr   (bus.rd_in),
      .wdata   (wb_data),
      .raddr_a (bus.rs_addr),
      .raddr_b (bus.rt_addr),
      .rdata_a (bank_rs),
      .rdata_b (bank_rt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_cnt_q <= '0;
      end else if (wb_valid) begin
         wr_cnt_q <= wr_cnt_q + 16'd1;
      end
   end

`ifdef WB_BYPASS_EN
   // wb_valid already excludes register 0, so a zero address never bypasses.
   always_comb begin
      bus.rs_data = (wb_valid && !reset && bus.rs_addr == bus.rd_in) ? wb_data : bank_rs;
      bus.rt_data = (wb_valid && !reset && bus.rt_addr == bus.rd_in) ? wb_data : bank_rt;
   end
`else
   always_comb begin
      bus.rs_data = bank_rs;
      bus.rt_data = bank_rt;
   end
`endif

   always_comb begin
      bus.wb_data  = wb_data;
      bus.wb_valid = wb_valid;
      bus.wr_count = wr_cnt_q;
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   logic [31:0] mregs [32];
   logic [15:0] mcount;

   wb_regfile_if #(.DATA_W(32)) bus ();

   wb_regfile #(
      .DATA_W   (32),
      .NUM_REGS (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_wb();
      return bus.MemtoReg ? bus.ReadData_in : bus.ALU_in;
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] addr);
      if (reset || addr == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
      if (bus.RegWrite && bus.rd_in != 5'd0 && addr == bus.rd_in) return exp_wb();
`endif
      return mregs[addr];
   endfunction

   // Reference model: an array of registers plus a commit counter.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
         mcount = 16'h0;
      end else if (bus.RegWrite && bus.rd_in != 5'd0) begin
         mregs[bus.rd_in] = exp_wb();
         mcount = mcount + 16'd1;
      end
   end

   always @(negedge clk) begin
      check("wb_data",  bus.wb_data, exp_wb());
      check("wb_valid", {31'h0, bus.wb_valid}, {31'h0, bus.RegWrite && bus.rd_in != 5'd0});
      check("wr_count", {16'h0, bus.wr_count}, {16'h0, mcount});
      check("rs_data",  bus.rs_data, exp_read(bus.rs_addr));
      check("rt_data",  bus.rt_data, exp_read(bus.rt_addr));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      bus.RegWrite    = 1'($urandom);
      bus.MemtoReg    = 1'($urandom);
      bus.ReadData_in = $urandom;
      bus.ALU_in      = $urandom;
      bus.rd_in       = 5'($urandom);
      bus.rs_addr     = 5'($urandom);
      bus.rt_addr     = 5'($urandom);
   endtask

   task automatic drive_write(input logic mem, input logic [31:0] rdata,
                              input logic [31:0] alu, input logic [4:0] rd);
      bus.RegWrite    = 1'b1;
      bus.MemtoReg    = mem;
      bus.ReadData_in = rdata;
      bus.ALU_in      = alu;
      bus.rd_in       = rd;
   endtask

   initial begin
      logic [4:0] save_rd;
      logic       save_we;
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      rand_inputs();
      bus.RegWrite = 1'b1;

      // Reset held with random writes: every register reads zero.
      for (int i = 1; i < 32; i++) begin
         step();
         rand_inputs();
         bus.rs_addr = 5'(i);
         bus.rt_addr = 5'(32 - i);
         @(negedge clk);
         check("reset_rs", bus.rs_data, 32'h0);
         check("reset_rt", bus.rt_data, 32'h0);
      end
      check("reset_cnt", {16'h0, bus.wr_count}, 32'h0);
      step();
      reset = 1'b0;
      bus.RegWrite = 1'b0;

      // ALU path write to r5.
      step();
      drive_write(1'b0, 32'h0, 32'h12345678, 5'd5);
      step();
      bus.RegWrite = 1'b0;
      bus.rs_addr  = 5'd5;
      @(negedge clk);
      check("mux_rs5", bus.rs_data, 32'h12345678);
      check("mux_cnt", {16'h0, bus.wr_count}, 32'd1);

      // Load path write to r31.
      step();
      drive_write(1'b1, 32'hDEADBEEF, 32'h1, 5'd31);
      @(negedge clk);
      check("load_wb", bus.wb_data, 32'hDEADBEEF);
      step();
      bus.RegWrite = 1'b0;
      bus.rs_addr  = 5'd31;
      @(negedge clk);
      check("load_r31", bus.rs_data, 32'hDEADBEEF);

      // Writes to register 0 are dropped.
      step();
      drive_write(1'b0, 32'h0, 32'hFFFFFFFF, 5'd0);
      bus.rs_addr = 5'd0;
      bus.rt_addr = 5'd0;
      @(negedge clk);
      check("r0_valid", {31'h0, bus.wb_valid}, 32'h0);
      check("r0_rs", bus.rs_data, 32'h0);
      step();
      bus.RegWrite = 1'b0;
      @(negedge clk);
      check("r0_rt", bus.rt_data, 32'h0);
      check("r0_cnt", {16'h0, bus.wr_count}, 32'd2);

      // Same-cycle write/read of r7.
      step();
      drive_write(1'b0, 32'h0, 32'hAAAA0000, 5'd7);
      step();
      drive_write(1'b0, 32'h0, 32'h00005555, 5'd7);
      bus.rt_addr = 5'd7;
      @(negedge clk);
`ifdef WB_BYPASS_EN
      check("bypass_same", bus.rt_data, 32'h00005555);
`else
      check("nobypass_same", bus.rt_data, 32'hAAAA0000);
`endif
      step();
      bus.RegWrite = 1'b0;
      @(negedge clk);
      check("bypass_next", bus.rt_data, 32'h00005555);
      check("bypass_cnt", {16'h0, bus.wr_count}, 32'd4);

      // Write coinciding with reset is discarded; first edge after release writes.
      step();
      drive_write(1'b0, 32'h0, 32'hCAFEF00D, 5'd9);
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive_write(1'b0, 32'h0, 32'h0BADF00D, 5'd9);
      bus.rs_addr = 5'd10;
      bus.rt_addr = 5'd5;
      @(negedge clk);
      check("rstwr_cnt", {16'h0, bus.wr_count}, 32'h0);
      check("rstwr_r5", bus.rt_data, 32'h0);
      step();
      bus.RegWrite = 1'b0;
      bus.rt_addr  = 5'd9;
      @(negedge clk);
      check("rstwr_r9", bus.rt_data, 32'h0BADF00D);
      check("rstwr_cnt1", {16'h0, bus.wr_count}, 32'd1);

      // Random traffic with between-edge glitches on rd_in/RegWrite.
      for (int n = 0; n < 400; n++) begin
         step();
         reset = ($urandom_range(0, 39) == 0);
         rand_inputs();
         if ($urandom_range(0, 3) == 0) begin
            save_rd = bus.rd_in;
            save_we = bus.RegWrite;
            #1;
            bus.rd_in    = 5'($urandom);
            bus.RegWrite = ~save_we;
            #1;
            bus.rd_in    = save_rd;
            bus.RegWrite = save_we;
         end
      end
      step();
      reset = 1'b0;
      bus.RegWrite = 1'b0;

      // Drive the counter to 0xFFFF, then one more write wraps it.
      for (int n = 0; n < 70000; n++) begin
         step();
         if (mcount == 16'hFFFF) break;
         rand_inputs();
         bus.RegWrite = 1'b1;
         bus.rd_in    = 5'($urandom_range(1, 31));
      end
      @(negedge clk);
      check("wrap_ffff", {16'h0, bus.wr_count}, 32'h0000FFFF);
      step();
      bus.RegWrite = 1'b0;
      @(negedge clk);
      check("wrap_zero", {16'h0, bus.wr_count}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
